display_startup_sequencer: RTL and testbench
============================================

DISPLAY_STARTUP_SEQUENCER -- requirements
Module: display_startup_sequencer

Interface
REQ-001 The block SHALL have parameter BLINKS, default 3, meaning the number of all-on/all-off self-test pairs (legal 1..15).
REQ-002 The block SHALL have parameter DIGITS, default 6, meaning the number of scanned 7-segment digits (legal 1..8).
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: scan_tick  in  1  one-clk enable pulse at scan rate (nominal 500 Hz).
REQ-005 Port: blink_tick  in  1  one-clk enable pulse at blink rate (nominal 2 Hz).
REQ-006 Port: restart  in  1  one-clk pulse that re-runs the self-test.
REQ-007 Port: run_seg  in  64  segment pattern, byte i [8i+7:8i] drives digit i.
REQ-008 Port: run_col  in  64  lattice column pattern, byte r [8r+7:8r] drives row r.
REQ-009 Port: row  out  8  lattice row select, active-low, one-cold.
REQ-010 Port: col  out  8  lattice column data, active-high.
REQ-011 Port: digit_cath  out  8  digit cathode select, active-low, one-cold.
REQ-012 Port: digit_seg  out  8  segment data, active-high.
REQ-013 Port: test_active  out  1  high while the self-test is running.
REQ-014 Port: done  out  1  one-clk pulse when the self-test completes.

Function
REQ-015 The FSM SHALL have states TEST_ON, TEST_OFF and RUN, plus a 4-bit blink counter blink_cnt.
REQ-016 In TEST_ON: col target 8'hFF, digit_seg target 8'hFF.
REQ-017 In TEST_OFF: col target 8'h00, digit_seg target 8'h00.
REQ-018 In RUN: col target run_col byte[row_idx], digit_seg target run_seg byte[dig_idx].
REQ-019 TEST_ON with blink_tick SHALL go to TEST_OFF.
REQ-020 TEST_OFF with blink_tick SHALL go to TEST_ON and increment blink_cnt when blink_cnt < BLINKS-1; otherwise it SHALL go to RUN and assert done for exactly one clk.
REQ-021 RUN SHALL ignore blink_tick.
REQ-022 restart in any state SHALL go to TEST_ON and clear blink_cnt, taking priority over a same-cycle blink_tick and suppressing any same-cycle done.
REQ-023 row_idx (3-bit) SHALL advance on scan_tick and wrap 7->0.
REQ-024 dig_idx SHALL advance on scan_tick and wrap DIGITS-1->0.
REQ-025 Scanning SHALL run in all states and SHALL NOT be reset by restart.
REQ-026 row, col, digit_cath, digit_seg and test_active SHALL be registered and load, every clk, the decode of the current state, indices and inputs (1-clk latency after a state or index change).
REQ-027 row SHALL be ~(8'b1 << row_idx) and digit_cath SHALL be ~(8'b1 << dig_idx).
REQ-028 digit_cath bits at DIGITS and above SHALL remain 1.
REQ-029 test_active SHALL be 1 in TEST_ON/TEST_OFF and 0 in RUN.
REQ-030 With no tick and no restart, all state, indices and outputs SHALL hold, except that col/digit_seg in RUN follow run_col/run_seg with 1-clk latency.
REQ-031 Simultaneous scan_tick and blink_tick SHALL both take effect in the same clk.

Reset
REQ-032 rst_n low SHALL immediately force state TEST_ON, blink_cnt=0, row_idx=0, dig_idx=0, row=8'hFF, digit_cath=8'hFF, col=8'h00, digit_seg=8'h00, test_active=1, done=0.
REQ-033 Reset asserted mid-test or in RUN SHALL abort the current operation with no done pulse.
REQ-034 The first clk after rst_n release SHALL load row=8'hFE, digit_cath=8'hFE, col=8'hFF, digit_seg=8'hFF.

Verification
REQ-035 Release reset, BLINKS=3, 6 blink_ticks -> col/digit_seg toggle FF,00 three times, done pulses once one clk after the 6th tick, then test_active=0.
REQ-036 In RUN, run_col byte 2=8'h3C, 3 scan_ticks -> row=8'hFB and col=8'h3C one clk after the 3rd tick.
REQ-037 DIGITS=6, 6 scan_ticks -> digit_cath sequence FE,FD,FB,F7,EF,DF,FE with bits 7:6 always 1; 8 scan_ticks -> row wraps 7F->FE.
REQ-038 restart and blink_tick in the same clk during the last TEST_OFF -> state TEST_ON, blink_cnt=0, no done pulse.
REQ-039 rst_n pulsed low in RUN mid-scan -> outputs reach reset values without waiting for clk, and the test sequence restarts.
REQ-040 scan_tick and blink_tick in the same clk -> row_idx advances and the FSM transitions together.

Source files
------------

// File: rtl/display_startup_sequencer_if.sv
// Signal bundle between the display sequencer and its owner: tick/restart
// controls and run patterns in, scanned lattice and 7-segment drive out.
interface display_startup_sequencer_if;
  logic        scan_tick;
  logic        blink_tick;
  logic        restart;
  logic [63:0] run_seg;
  logic [63:0] run_col;
  logic [7:0]  row;
  logic [7:0]  col;
  logic [7:0]  digit_cath;
  logic [7:0]  digit_seg;
  logic        test_active;
  logic        done;

  modport master (
    output scan_tick, blink_tick, restart, run_seg, run_col,
    input  row, col, digit_cath, digit_seg, test_active, done
  );

  modport slave (
    input  scan_tick, blink_tick, restart, run_seg, run_col,
    output row, col, digit_cath, digit_seg, test_active, done
  );
endinterface

// File: rtl/display_startup_sequencer.sv
// Power-up lamp test (BLINKS all-on/all-off pairs) then live row/digit scanning;
// all drive outputs registered, 1 clk after state/index change; no backpressure.
module display_startup_sequencer #(
  parameter int BLINKS = 3,
  parameter int DIGITS = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  display_startup_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    TEST_ON  = 2'd0,
    TEST_OFF = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BLINK = 4'(BLINKS - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);

  state_t     state, state_nxt;
  logic [3:0] blink_cnt, blink_cnt_nxt;
  logic       done_nxt;
  logic [2:0] row_idx;
  logic [2:0] dig_idx;
  logic [7:0] col_nxt;
  logic [7:0] seg_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TEST_ON;
      blink_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_cnt_nxt;
    end
  end

  // restart wins over blink_tick and swallows a same-cycle completion
  always_comb begin
    state_nxt     = state;
    blink_cnt_nxt = blink_cnt;
    done_nxt      = 1'b0;
    col_nxt       = 8'h00;
    seg_nxt       = 8'h00;
    case (state)
      TEST_ON: begin
        col_nxt = 8'hFF;
        seg_nxt = 8'hFF;
        if (bus.blink_tick) state_nxt = TEST_OFF;
      end
      TEST_OFF: begin
        if (bus.blink_tick) begin
          if (blink_cnt < LAST_BLINK) begin
            state_nxt     = TEST_ON;
            blink_cnt_nxt = blink_cnt + 4'd1;
          end else begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        col_nxt = bus.run_col[row_idx*8 +: 8];
        seg_nxt = bus.run_seg[dig_idx*8 +: 8];
      end
      default: state_nxt = TEST_ON;
    endcase
    if (bus.restart) begin
      state_nxt     = TEST_ON;
      blink_cnt_nxt = 4'd0;
      done_nxt      = 1'b0;
    end
  end

  // Scan indices free-run in every state; only rst_n brings them back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx <= 3'd0;
      dig_idx <= 3'd0;
    end else if (bus.scan_tick) begin
      row_idx <= row_idx + 3'd1;
      dig_idx <= (dig_idx == LAST_DIGIT) ? 3'd0 : dig_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.row         <= 8'hFF;
      bus.digit_cath  <= 8'hFF;
      bus.col         <= 8'h00;
      bus.digit_seg   <= 8'h00;
      bus.test_active <= 1'b1;
      bus.done        <= 1'b0;
    end else begin
      bus.row         <= ~(8'b1 << row_idx);
      bus.digit_cath  <= ~(8'b1 << dig_idx);
      bus.col         <= col_nxt;
      bus.digit_seg   <= seg_nxt;
      bus.test_active <= (state != RUN);
      bus.done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_display_startup_sequencer.sv
// Directed bench for display_startup_sequencer at BLINKS=3, DIGITS=6.
module tb_display_startup_sequencer;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errs;

  display_startup_sequencer_if bus ();

  display_startup_sequencer #(.BLINKS(3), .DIGITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] row_exp  [8];
  logic [7:0] cath_exp [8];

  initial begin
    vectors = 0;
    errs    = 0;
    row_exp  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    cath_exp = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFE, 8'hFD};
    rst_n          = 1'b1;
    bus.scan_tick  = 1'b0;
    bus.blink_tick = 1'b0;
    bus.restart    = 1'b0;
    bus.run_col    = 64'h0000_0000_5A3C_4281;
    bus.run_seg    = 64'h0000_0000_005B_063F;

    // Reset values appear without a clock edge
    #2 rst_n = 1'b0;
    #2;
    chk("rst_row",  bus.row,        8'hFF);
    chk("rst_cath", bus.digit_cath, 8'hFF);
    chk("rst_col",  bus.col,        8'h00);
    chk("rst_seg",  bus.digit_seg,  8'h00);
    chk("rst_ta",   {7'b0, bus.test_active}, 8'h01);
    chk("rst_done", {7'b0, bus.done},        8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;

    step();
    chk("first_row",  bus.row,        8'hFE);
    chk("first_cath", bus.digit_cath, 8'hFE);
    chk("first_col",  bus.col,        8'hFF);
    chk("first_seg",  bus.digit_seg,  8'hFF);

    // Six blink ticks: FF/00 three times, done one clk after the sixth
    for (int i = 1; i <= 6; i++) begin
      bus.blink_tick = 1'b1;
      step();
      bus.blink_tick = 1'b0;
      chk("blink_done", {7'b0, bus.done}, (i == 6) ? 8'h01 : 8'h00);
      step();
      chk("blink_col", bus.col,       (i == 6) ? 8'h81 : ((i % 2 == 1) ? 8'h00 : 8'hFF));
      chk("blink_seg", bus.digit_seg, (i == 6) ? 8'h3F : ((i % 2 == 1) ? 8'h00 : 8'hFF));
    end
    chk("run_done_low", {7'b0, bus.done},        8'h00);
    chk("run_ta",       {7'b0, bus.test_active}, 8'h00);

    // RUN ignores blink_tick and tracks run_col with 1-clk latency
    bus.blink_tick = 1'b1;
    bus.run_col    = 64'h0000_0000_5A3C_42E7;
    step();
    bus.blink_tick = 1'b0;
    step();
    chk("run_follow_col", bus.col,                8'hE7);
    chk("run_ignore_ta",  {7'b0, bus.test_active}, 8'h00);

    // Three scan ticks in RUN
    for (int i = 0; i < 3; i++) begin
      bus.scan_tick = 1'b1;
      step();
    end
    bus.scan_tick = 1'b0;
    chk("scan3_row", bus.row,       8'hFB);
    chk("scan3_col", bus.col,       8'h3C);
    chk("scan3_seg", bus.digit_seg, 8'h5B);
    step();
    chk("scan4_row", bus.row,       8'hF7);
    chk("scan4_col", bus.col,       8'h5A);
    chk("scan4_seg", bus.digit_seg, 8'h00);

    // Asynchronous reset mid-scan in RUN
    rst_n = 1'b0;
    #1;
    chk("arst_row",  bus.row,        8'hFF);
    chk("arst_cath", bus.digit_cath, 8'hFF);
    chk("arst_col",  bus.col,        8'h00);
    chk("arst_seg",  bus.digit_seg,  8'h00);
    chk("arst_ta",   {7'b0, bus.test_active}, 8'h01);
    #2 rst_n = 1'b1;
    step();
    chk("rerun_row", bus.row, 8'hFE);
    chk("rerun_col", bus.col, 8'hFF);
    chk("rerun_ta",  {7'b0, bus.test_active}, 8'h01);

    // Row and digit wrap
    for (int i = 0; i < 8; i++) begin
      bus.scan_tick = 1'b1;
      step();
      chk("wrap_row",  bus.row,        row_exp[i]);
      chk("wrap_cath", bus.digit_cath, cath_exp[i]);
    end
    bus.scan_tick = 1'b0;
    step();
    chk("wrap_row_end",  bus.row,        8'hFE);
    chk("wrap_cath_end", bus.digit_cath, 8'hFB);

    // Simultaneous scan and blink tick
    bus.scan_tick  = 1'b1;
    bus.blink_tick = 1'b1;
    step();
    bus.scan_tick  = 1'b0;
    bus.blink_tick = 1'b0;
    step();
    chk("both_row", bus.row, 8'hFD);
    chk("both_col", bus.col, 8'h00);

    // Reach last TEST_OFF, then restart together with blink_tick
    for (int i = 0; i < 4; i++) begin
      bus.blink_tick = 1'b1;
      step();
      bus.blink_tick = 1'b0;
      chk("pre_done", {7'b0, bus.done}, 8'h00);
    end
    bus.blink_tick = 1'b1;
    bus.restart    = 1'b1;
    step();
    bus.blink_tick = 1'b0;
    bus.restart    = 1'b0;
    chk("rs_done", {7'b0, bus.done}, 8'h00);
    step();
    chk("rs_done2", {7'b0, bus.done},        8'h00);
    chk("rs_col",   bus.col,                 8'hFF);
    chk("rs_ta",    {7'b0, bus.test_active}, 8'h01);
    // blink_cnt cleared: a full six ticks are needed again
    for (int i = 1; i <= 6; i++) begin
      bus.blink_tick = 1'b1;
      step();
      bus.blink_tick = 1'b0;
      chk("rs_seq_done", {7'b0, bus.done}, (i == 6) ? 8'h01 : 8'h00);
    end
    step();
    chk("rs_seq_ta", {7'b0, bus.test_active}, 8'h00);

    // restart from RUN
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    step();
    chk("run_restart_ta",  {7'b0, bus.test_active}, 8'h01);
    chk("run_restart_col", bus.col,                 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
